// File: rtl/itlb_pkg.sv
// Shared types and constants for the instruction TLB.
// Contents:
//   pte_t            Sv32 leaf PTE as returned by the L2 TLB walker
//   itlb_4kb_entry_t 4KB-page array entry {tag, PPN, U, X, A, valid}
//   itlb_4mb_entry_t 4MB-page array entry {tag, PPN1, U, X, A, valid}
//   miss_state_t     miss FSM states
package itlb_pkg;

    localparam int unsigned ITLB_4KBPAGE_ENTRIES = 32;
    localparam int unsigned ITLB_4KBPAGE_ASSOC   = 2;
    localparam int unsigned ITLB_4KBPAGE_SETS    = ITLB_4KBPAGE_ENTRIES / ITLB_4KBPAGE_ASSOC;
    localparam int unsigned ITLB_4MBPAGE_ENTRIES = 4;

    // 4KB: index VPN[3:0], tag VPN[19:4]. 4MB: index VPN[11:10], tag VPN[19:12].
    localparam int unsigned ITLB_4KB_INDEX_W = 4;
    localparam int unsigned ITLB_4KB_TAG_W   = 16;
    localparam int unsigned ITLB_4MB_INDEX_W = 2;
    localparam int unsigned ITLB_4MB_TAG_W   = 8;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic [ITLB_4KB_TAG_W-1:0] tag;
        logic [21:0]               ppn;
        logic                      u;
        logic                      x;
        logic                      a;
        logic                      valid;
    } itlb_4kb_entry_t;

    typedef struct packed {
        logic [ITLB_4MB_TAG_W-1:0] tag;
        logic [11:0]               ppn1;
        logic                      u;
        logic                      x;
        logic                      a;
        logic                      valid;
    } itlb_4mb_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } miss_state_t;

endpackage

// File: rtl/itlb_miss_fsm.sv
// Single-outstanding miss handler between the ITLB and the L2 TLB.
// Holds the in-flight VPN, the discard flag for walks overtaken by a flush,
// and the one-entry fault record for walks that returned a page fault.
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   lookup_miss/_vpn     lookup missed (no array or fault-record hit) and its VPN
//   flush_valid          sfence.vma
//   miss_req_*           walk request handshake to l2_tlb
//   miss_resp_*          walk result pulse from l2_tlb
//   fill_valid/_vpn      write the returned PTE into the arrays this cycle
//   fault_valid/_vpn     fault record contents
module itlb_miss_fsm
    import itlb_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        lookup_miss,
    input  logic [19:0] lookup_vpn,
    input  logic        flush_valid,
    output logic        miss_req_valid,
    output logic [19:0] miss_req_VPN,
    input  logic        miss_req_ready,
    input  logic        miss_resp_valid,
    input  logic        miss_resp_page_fault,
    output logic        fill_valid,
    output logic [19:0] fill_vpn,
    output logic        fault_valid,
    output logic [19:0] fault_vpn
);

    miss_state_t state_q;
    logic        discard_q;

    // A flush in the response cycle wins over the fill.
    assign fill_valid = (state_q == StWait) && miss_resp_valid && !miss_resp_page_fault &&
                        !discard_q && !flush_valid;
    assign fill_vpn   = miss_req_VPN;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q        <= StIdle;
            discard_q      <= 1'b0;
            miss_req_valid <= 1'b0;
            miss_req_VPN   <= '0;
            fault_valid    <= 1'b0;
            fault_vpn      <= '0;
        end else begin
            if (flush_valid) begin
                fault_valid <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (lookup_miss) begin
                        state_q        <= StReq;
                        miss_req_valid <= 1'b1;
                        miss_req_VPN   <= lookup_vpn;
                        // The missing lookup predates a same-cycle flush; its walk is stale.
                        discard_q      <= flush_valid;
                    end
                end
                StReq: begin
                    if (flush_valid) begin
                        discard_q <= 1'b1;
                    end
                    if (miss_req_ready) begin
                        state_q        <= StWait;
                        miss_req_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (flush_valid) begin
                        discard_q <= 1'b1;
                    end
                    if (miss_resp_valid) begin
                        state_q   <= StIdle;
                        discard_q <= 1'b0;
                        if (!discard_q && !flush_valid) begin
                            // A fault loads the record; a good fill retires any old one.
                            fault_valid <= miss_resp_page_fault;
                            if (miss_resp_page_fault) begin
                                fault_vpn <= miss_req_VPN;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/itlb.sv
// Instruction TLB: 1-cycle VPN->PPN translation for the fetch path.
// 4KB array: 2-way x 16 sets with 1 LRU bit per set; 4MB array: 4 direct-mapped entries.
// Ports:
//   CLK, nRST         clock, synchronous active-low reset
//   req_*             lookup request (registered, answered next cycle on resp_*)
//   resp_*            response: hit, PPN, instruction page fault
//   miss_req_*        walk request to l2_tlb
//   miss_resp_*       walk result from l2_tlb
//   flush_valid       sfence.vma, invalidate everything
module itlb
    import itlb_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req_valid,
    input  logic [19:0] req_VPN,
    input  logic        req_user_mode,
    output logic        resp_valid,
    output logic        resp_hit,
    output logic [21:0] resp_PPN,
    output logic        resp_page_fault,
    output logic        miss_req_valid,
    output logic [19:0] miss_req_VPN,
    input  logic        miss_req_ready,
    input  logic        miss_resp_valid,
    input  logic [31:0] miss_resp_pte,
    input  logic        miss_resp_superpage,
    input  logic        miss_resp_page_fault,
    input  logic        flush_valid
);

    logic            req_valid_q;
    logic [19:0]     req_vpn_q;
    logic            req_user_q;

    itlb_4kb_entry_t e4k_q [ITLB_4KBPAGE_ASSOC][ITLB_4KBPAGE_SETS];
    logic [ITLB_4KBPAGE_SETS-1:0] lru_q;  // lru_q[set] = way to evict next
    itlb_4mb_entry_t e4m_q [ITLB_4MBPAGE_ENTRIES];

    // Lookup against the registered request.
    logic [ITLB_4KB_INDEX_W-1:0] set_idx;
    logic [ITLB_4MB_INDEX_W-1:0] sp_idx;
    itlb_4kb_entry_t             way0, way1, sel4k;
    itlb_4mb_entry_t             spe;
    logic                        hit0, hit1, hit_4k, hit_sp, any_hit, hit_way;
    logic                        hit_u, hit_x, hit_a, perm_fault, fr_hit, lookup_miss;
    logic [21:0]                 hit_ppn;
    logic                        fault_valid;
    logic [19:0]                 fault_vpn;

    assign set_idx = req_vpn_q[3:0];
    assign sp_idx  = req_vpn_q[11:10];
    assign way0    = e4k_q[0][set_idx];
    assign way1    = e4k_q[1][set_idx];
    assign spe     = e4m_q[sp_idx];
    assign hit0    = way0.valid && (way0.tag == req_vpn_q[19:4]);
    assign hit1    = way1.valid && (way1.tag == req_vpn_q[19:4]);
    assign hit_4k  = hit0 || hit1;
    assign hit_way = !hit0;
    assign sel4k   = hit0 ? way0 : way1;
    assign hit_sp  = spe.valid && (spe.tag == req_vpn_q[19:12]);
    assign any_hit = hit_4k || hit_sp;

    // 4KB wins when both arrays match.
    always_comb begin
        hit_u   = spe.u;
        hit_x   = spe.x;
        hit_a   = spe.a;
        hit_ppn = {spe.ppn1, req_vpn_q[9:0]};
        if (hit_4k) begin
            hit_u   = sel4k.u;
            hit_x   = sel4k.x;
            hit_a   = sel4k.a;
            hit_ppn = sel4k.ppn;
        end
    end

    // Fetch requires X and A, and the U bit must match the privilege exactly.
    assign perm_fault = !hit_x || !hit_a || (req_user_q != hit_u);
    assign fr_hit     = fault_valid && (fault_vpn == req_vpn_q);
    assign lookup_miss = req_valid_q && !any_hit && !fr_hit;

    assign resp_valid      = req_valid_q;
    assign resp_hit        = req_valid_q && any_hit;
    assign resp_page_fault = req_valid_q && (any_hit ? perm_fault : fr_hit);
    assign resp_PPN        = resp_hit ? hit_ppn : '0;

    // Fill path.
    pte_t                        pte;
    logic                        fill_valid;
    logic [19:0]                 fill_vpn;
    logic [ITLB_4KB_INDEX_W-1:0] fill_set;
    logic                        fill_way;
    itlb_4kb_entry_t             new4k;
    itlb_4mb_entry_t             new4m;
    logic                        unused_pte;

    assign pte        = pte_t'(miss_resp_pte);
    assign unused_pte = ^{pte.rsw, pte.d, pte.g, pte.w, pte.r, pte.v};
    assign fill_set   = fill_vpn[3:0];

    always_comb begin
        if (!e4k_q[0][fill_set].valid) begin
            fill_way = 1'b0;
        end else if (!e4k_q[1][fill_set].valid) begin
            fill_way = 1'b1;
        end else begin
            fill_way = lru_q[fill_set];
        end
    end

    assign new4k = '{tag: fill_vpn[19:4], ppn: {pte.ppn1, pte.ppn0},
                     u: pte.u, x: pte.x, a: pte.a, valid: 1'b1};
    assign new4m = '{tag: fill_vpn[19:12], ppn1: pte.ppn1,
                     u: pte.u, x: pte.x, a: pte.a, valid: 1'b1};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            req_valid_q <= 1'b0;
            req_vpn_q   <= '0;
            req_user_q  <= 1'b0;
            lru_q       <= '0;
            for (int w = 0; w < ITLB_4KBPAGE_ASSOC; w++) begin
                for (int s = 0; s < ITLB_4KBPAGE_SETS; s++) begin
                    e4k_q[w][s] <= '0;
                end
            end
            for (int i = 0; i < ITLB_4MBPAGE_ENTRIES; i++) begin
                e4m_q[i] <= '0;
            end
        end else begin
            req_valid_q <= req_valid;
            req_vpn_q   <= req_VPN;
            req_user_q  <= req_user_mode;
            if (flush_valid) begin
                lru_q <= '0;
                for (int w = 0; w < ITLB_4KBPAGE_ASSOC; w++) begin
                    for (int s = 0; s < ITLB_4KBPAGE_SETS; s++) begin
                        e4k_q[w][s].valid <= 1'b0;
                    end
                end
                for (int i = 0; i < ITLB_4MBPAGE_ENTRIES; i++) begin
                    e4m_q[i].valid <= 1'b0;
                end
            end else begin
                if (req_valid_q && hit_4k && !perm_fault) begin
                    lru_q[set_idx] <= !hit_way;
                end
                // Placed after the hit update so a fill into the same set decides LRU.
                if (fill_valid) begin
                    if (miss_resp_superpage) begin
                        e4m_q[fill_vpn[11:10]] <= new4m;
                    end else begin
                        e4k_q[fill_way][fill_set] <= new4k;
                        lru_q[fill_set]           <= !fill_way;
                    end
                end
            end
        end
    end

    itlb_miss_fsm u_miss_fsm (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .lookup_miss          (lookup_miss),
        .lookup_vpn           (req_vpn_q),
        .flush_valid          (flush_valid),
        .miss_req_valid       (miss_req_valid),
        .miss_req_VPN         (miss_req_VPN),
        .miss_req_ready       (miss_req_ready),
        .miss_resp_valid      (miss_resp_valid),
        .miss_resp_page_fault (miss_resp_page_fault),
        .fill_valid           (fill_valid),
        .fill_vpn             (fill_vpn),
        .fault_valid          (fault_valid),
        .fault_vpn            (fault_vpn)
    );

endmodule

// File: tb/tb_itlb.sv
// Directed bench for itlb: miss/fill, superpage, LRU, permission and walk faults,
// flush interactions and reset during a pending walk.
module tb_itlb;
    import itlb_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        req_valid;
    logic [19:0] req_VPN;
    logic        req_user_mode;
    logic        resp_valid;
    logic        resp_hit;
    logic [21:0] resp_PPN;
    logic        resp_page_fault;
    logic        miss_req_valid;
    logic [19:0] miss_req_VPN;
    logic        miss_req_ready;
    logic        miss_resp_valid;
    logic [31:0] miss_resp_pte;
    logic        miss_resp_superpage;
    logic        miss_resp_page_fault;
    logic        flush_valid;

    int vectors = 0;
    int miscompares = 0;

    itlb dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .req_valid            (req_valid),
        .req_VPN              (req_VPN),
        .req_user_mode        (req_user_mode),
        .resp_valid           (resp_valid),
        .resp_hit             (resp_hit),
        .resp_PPN             (resp_PPN),
        .resp_page_fault      (resp_page_fault),
        .miss_req_valid       (miss_req_valid),
        .miss_req_VPN         (miss_req_VPN),
        .miss_req_ready       (miss_req_ready),
        .miss_resp_valid      (miss_resp_valid),
        .miss_resp_pte        (miss_resp_pte),
        .miss_resp_superpage  (miss_resp_superpage),
        .miss_resp_page_fault (miss_resp_page_fault),
        .flush_valid          (flush_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pte_t mk_pte(input logic [21:0] ppn, input logic u, input logic x,
                                    input logic a);
        pte_t p;
        p      = '0;
        p.ppn1 = ppn[21:10];
        p.ppn0 = ppn[9:0];
        p.u    = u;
        p.x    = x;
        p.a    = a;
        p.r    = 1'b1;
        p.v    = 1'b1;
        return p;
    endfunction

    // Issue one lookup, sample its response one cycle later.
    task automatic look(input string tag, input logic [19:0] vpn, input logic user,
                        input logic eh, input logic epf, input logic [21:0] eppn);
        req_valid     = 1'b1;
        req_VPN       = vpn;
        req_user_mode = user;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".hit"}, 32'(resp_hit), 32'(eh));
        chk({tag, ".pf"}, 32'(resp_page_fault), 32'(epf));
        chk({tag, ".ppn"}, 32'(resp_PPN), 32'(eppn));
    endtask

    task automatic wait_req(input string tag, input logic [19:0] vpn);
        int n = 0;
        while (!miss_req_valid && n < 16) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, ".req_valid"}, 32'(miss_req_valid), 32'd1);
        chk({tag, ".req_vpn"}, 32'(miss_req_VPN), 32'(vpn));
    endtask

    task automatic handshake(input string tag);
        miss_req_ready = 1'b1;
        @(posedge CLK); #1;
        miss_req_ready = 1'b0;
        chk({tag, ".req_drop"}, 32'(miss_req_valid), 32'd0);
    endtask

    task automatic respond(input pte_t p, input logic sp, input logic fault);
        miss_resp_valid      = 1'b1;
        miss_resp_pte        = p;
        miss_resp_superpage  = sp;
        miss_resp_page_fault = fault;
        @(posedge CLK); #1;
        miss_resp_valid      = 1'b0;
        miss_resp_page_fault = 1'b0;
        miss_resp_superpage  = 1'b0;
    endtask

    task automatic walk(input string tag, input logic [19:0] vpn, input pte_t p,
                        input logic sp, input logic fault);
        wait_req(tag, vpn);
        handshake(tag);
        respond(p, sp, fault);
    endtask

    initial begin
        nRST                 = 1'b0;
        req_valid            = 1'b0;
        req_VPN              = '0;
        req_user_mode        = 1'b0;
        miss_req_ready       = 1'b0;
        miss_resp_valid      = 1'b0;
        miss_resp_pte        = '0;
        miss_resp_superpage  = 1'b0;
        miss_resp_page_fault = 1'b0;
        flush_valid          = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Reset state.
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_hit", 32'(resp_hit), 32'd0);
        chk("rst.resp_ppn", 32'(resp_PPN), 32'd0);
        chk("rst.resp_pf", 32'(resp_page_fault), 32'd0);
        chk("rst.miss_req", 32'(miss_req_valid), 32'd0);

        // Cold miss, request held until ready, lookup during WAIT, fill and hit.
        look("cold", 20'h12345, 1'b0, 1'b0, 1'b0, 22'h0);
        wait_req("cold", 20'h12345);
        @(posedge CLK); #1;
        chk("cold.hold_valid", 32'(miss_req_valid), 32'd1);
        chk("cold.hold_vpn", 32'(miss_req_VPN), 32'h12345);
        handshake("cold");
        look("in_wait", 20'h12345, 1'b0, 1'b0, 1'b0, 22'h0);
        @(posedge CLK); #1;
        chk("in_wait.no_req", 32'(miss_req_valid), 32'd0);
        respond(mk_pte(22'h2ABCD, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("hit4k", 20'h12345, 1'b0, 1'b1, 1'b0, 22'h2ABCD);

        // Superpage.
        look("sp_miss", 20'h80155, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("sp", 20'h80155, mk_pte(22'h3CC00, 1'b0, 1'b1, 1'b1), 1'b1, 1'b0);
        look("sp_hit", 20'h80155, 1'b0, 1'b1, 1'b0, 22'h3CD55);

        // U-mode fetch of supervisor pages.
        look("perm4k", 20'h12345, 1'b1, 1'b1, 1'b1, 22'h2ABCD);
        look("perm4m", 20'h80155, 1'b1, 1'b1, 1'b1, 22'h3CD55);
        @(posedge CLK); #1;
        chk("perm.no_req", 32'(miss_req_valid), 32'd0);

        // Walk fault lands in the fault record; no further walks for that VPN.
        look("wf_miss", 20'h00777, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("wf", 20'h00777, mk_pte(22'h0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);
        look("wf_rec1", 20'h00777, 1'b0, 1'b0, 1'b1, 22'h0);
        @(posedge CLK); #1;
        chk("wf.no_req", 32'(miss_req_valid), 32'd0);
        look("wf_rec2", 20'h00777, 1'b0, 1'b0, 1'b1, 22'h0);

        // Flush in the cycle of a lookup: the lookup sees pre-flush state.
        req_valid     = 1'b1;
        req_VPN       = 20'h12345;
        req_user_mode = 1'b0;
        @(posedge CLK); #1;
        req_valid   = 1'b0;
        flush_valid = 1'b1;
        chk("flush_cyc.hit", 32'(resp_hit), 32'd1);
        chk("flush_cyc.ppn", 32'(resp_PPN), 32'h2ABCD);
        @(posedge CLK); #1;
        flush_valid = 1'b0;
        look("post_flush", 20'h12345, 1'b0, 1'b0, 1'b0, 22'h0);
        look("rec_flushed", 20'h00777, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("pf_walk", 20'h12345, mk_pte(22'h0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);

        // LRU in set 5: third fill evicts 0x00015, 0x00005 stays.
        look("s5_a", 20'h00005, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("s5_a", 20'h00005, mk_pte(22'h00100, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("s5_a_hit1", 20'h00005, 1'b0, 1'b1, 1'b0, 22'h00100);
        look("s5_b", 20'h00015, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("s5_b", 20'h00015, mk_pte(22'h00200, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("s5_a_hit2", 20'h00005, 1'b0, 1'b1, 1'b0, 22'h00100);
        look("s5_c", 20'h00025, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("s5_c", 20'h00025, mk_pte(22'h00300, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("s5_a_hit3", 20'h00005, 1'b0, 1'b1, 1'b0, 22'h00100);
        look("s5_c_hit", 20'h00025, 1'b0, 1'b1, 1'b0, 22'h00300);
        look("s5_b_evicted", 20'h00015, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("s5_b2", 20'h00015, mk_pte(22'h0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);

        // Flush while waiting: the returning fill is dropped.
        look("fw_miss", 20'h00999, 1'b0, 1'b0, 1'b0, 22'h0);
        wait_req("fw", 20'h00999);
        handshake("fw");
        flush_valid = 1'b1;
        @(posedge CLK); #1;
        flush_valid = 1'b0;
        respond(mk_pte(22'h00999, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("fw_dropped", 20'h00999, 1'b0, 1'b0, 1'b0, 22'h0);
        walk("fw_retry", 20'h00999, mk_pte(22'h00999, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("fw_hit", 20'h00999, 1'b0, 1'b1, 1'b0, 22'h00999);

        // Reset during REQ; a stray response in IDLE is ignored.
        look("rr_miss", 20'h00ABC, 1'b0, 1'b0, 1'b0, 22'h0);
        wait_req("rr", 20'h00ABC);
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        chk("rr.req_cleared", 32'(miss_req_valid), 32'd0);
        chk("rr.resp_valid", 32'(resp_valid), 32'd0);
        respond(mk_pte(22'h00ABC, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0);
        look("rr_entry_gone", 20'h00999, 1'b0, 1'b0, 1'b0, 22'h0);
        wait_req("rr_new", 20'h00999);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
